// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C widths, target FSM state encoding and address-match helper.
package i2c_pkg;
    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK, SKIP
    } i2c_target_state_t;

    // The general call address never matches, whatever the configured address is.
    function automatic logic addr_hit(input logic [I2C_ADDR_WIDTH-1:0] a,
                                      input logic [I2C_ADDR_WIDTH-1:0] t);
        return (a == t) && (a != '0);
    endfunction
endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: bus lines and byte handshake between an I2C target and its user.
interface i2c_target_if;
    import i2c_pkg::*;
    logic scl_i, sda_i, scl_o, sda_o;
    logic start_o, rw_o, stop_o, rx_valid_o, tx_req_o, tx_valid_i, tx_nack_o, busy_o;
    logic [I2C_DATA_WIDTH-1:0] rx_data_o, tx_data_i;

    modport slave (
        input  scl_i, sda_i, tx_data_i, tx_valid_i,
        output scl_o, sda_o, start_o, rw_o, stop_o, rx_data_o, rx_valid_o,
               tx_req_o, tx_nack_o, busy_o
    );
    modport master (
        output scl_i, sda_i, tx_data_i, tx_valid_i,
        input  scl_o, sda_o, start_o, rw_o, stop_o, rx_data_o, rx_valid_o,
               tx_req_o, tx_nack_o, busy_o
    );
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizer for one bus line with rise/fall pulses.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] s;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) s <= '1;
        else s <= {s[1:0], d};

    assign q    = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target; receives written bytes, serves read bytes with clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22
) (
    input logic          clk_i,
    input logic          rst_i,
    i2c_target_if.slave  bus
);
    i2c_target_state_t state, nxt;
    logic scl_q, scl_rise, scl_fall, sda_q, sda_rise, sda_fall;
    logic start_c, stop_c, match, sda_r, busy, rw, start_p, stop_p, rx_valid, tx_nack;
    logic [3:0] cnt;
    logic [I2C_DATA_WIDTH-1:0] sr, rx_data;

    i2c_line_sync u_scl (.clk_i, .rst_i, .d(bus.scl_i), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk_i, .rst_i, .d(bus.sda_i), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

    // scl must already have been high on the previous sample, so a read MSB launched
    // together with the end of a stretch is never taken for START/STOP.
    assign start_c = sda_fall & scl_q & ~scl_rise;
    assign stop_c  = sda_rise & scl_q & ~scl_rise;
    assign match   = addr_hit(sr[7:1], TARGET_ADDR);

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        if (start_c) nxt = ADDR;
        else if (stop_c) nxt = IDLE;
        else
            case (state)
                ADDR:     if (scl_fall && cnt == 4'd8) nxt = match ? ADDR_ACK : SKIP;
                ADDR_ACK: if (scl_fall) nxt = rw ? RD_WAIT : WR_DATA;
                WR_DATA:  if (scl_fall && cnt == 4'd8) nxt = WR_ACK;
                WR_ACK:   if (scl_fall) nxt = WR_DATA;
                RD_WAIT:  if (bus.tx_valid_i) nxt = RD_DATA;
                RD_DATA:  if (scl_fall && cnt == 4'd8) nxt = RD_ACK;
                RD_ACK:   nxt = (scl_rise && sda_q) ? SKIP : (scl_fall && cnt == 4'd9) ? RD_WAIT : RD_ACK;
                default:  nxt = state;
            endcase
    end

    always_comb begin
        bus.scl_o    = state != RD_WAIT;
        bus.tx_req_o = state == RD_WAIT;
    end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            cnt <= '0; sr <= '0; sda_r <= 1'b1; rx_data <= '0; rx_valid <= 1'b0; busy <= 1'b0;
            rw <= 1'b0; start_p <= 1'b0; stop_p <= 1'b0; tx_nack <= 1'b0;
        end else begin
            rx_valid <= 1'b0; start_p <= 1'b0; stop_p <= 1'b0; tx_nack <= 1'b0;
            if (start_c) begin
                cnt <= '0; sda_r <= 1'b1; busy <= 1'b0;
            end else if (stop_c) begin
                sda_r <= 1'b1; busy <= 1'b0; stop_p <= busy;
            end else
                case (state)
                    ADDR:
                        if (scl_rise) begin
                            sr <= {sr[6:0], sda_q}; cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8 && match) begin
                            start_p <= 1'b1; rw <= sr[0]; busy <= 1'b1; sda_r <= 1'b0;
                        end
                    ADDR_ACK, WR_ACK:
                        if (scl_fall) begin
                            sda_r <= 1'b1; cnt <= '0;
                        end
                    WR_DATA:
                        if (scl_rise) begin
                            sr <= {sr[6:0], sda_q}; cnt <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                rx_data <= {sr[6:0], sda_q}; rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && cnt == 4'd8) sda_r <= 1'b0;
                    RD_WAIT:
                        if (bus.tx_valid_i) begin
                            sda_r <= bus.tx_data_i[7]; sr <= {bus.tx_data_i[6:0], 1'b0}; cnt <= 4'd1;
                        end
                    RD_DATA:
                        if (scl_fall) begin
                            sda_r <= (cnt == 4'd8) ? 1'b1 : sr[7];
                            sr <= {sr[6:0], 1'b0};
                            cnt <= (cnt == 4'd8) ? cnt : cnt + 4'd1;
                        end
                    RD_ACK:
                        if (scl_rise) begin
                            tx_nack <= sda_q; cnt <= sda_q ? cnt : 4'd9;
                        end
                    default: sda_r <= 1'b1;
                endcase
        end

    assign bus.sda_o      = sda_r;
    assign bus.start_o    = start_p;
    assign bus.stop_o     = stop_p;
    assign bus.rw_o       = rw;
    assign bus.busy_o     = busy;
    assign bus.rx_data_o  = rx_data;
    assign bus.rx_valid_o = rx_valid;
    assign bus.tx_nack_o  = tx_nack;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master with scoreboard queues for written and read bytes.
module tb_i2c_target;
    localparam int T = 10;
    logic clk = 0, rst_n = 0, m_scl = 1, m_sda = 1, tx_valid = 0, tx_force = 0, req_d = 0;
    logic [7:0] tx_data = 0;
    int checks = 0, errors = 0, tx_delay = 3;
    int n_start = 0, n_stop = 0, n_nack = 0, n_req = 0, n_rx = 0, n_stretch = 0;
    logic [7:0] tx_q[$], exp_rx[$], exp_rd[$];

    i2c_target_if bus ();
    assign bus.scl_i      = m_scl & bus.scl_o;
    assign bus.sda_i      = m_sda & bus.sda_o;
    assign bus.tx_valid_i = tx_valid;
    assign bus.tx_data_i  = tx_data;

    i2c_target #(.TARGET_ADDR(7'h22)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // output monitor: pulse counters and written-byte scoreboard
    initial forever begin
        @(negedge clk);
        if (bus.start_o) n_start++;
        if (bus.stop_o) n_stop++;
        if (bus.tx_nack_o) n_nack++;
        if (bus.tx_req_o && !req_d) n_req++;
        req_d = bus.tx_req_o;
        if (!bus.scl_o) n_stretch++;
        if (bus.rx_valid_o) begin
            n_rx++;
            if (exp_rx.size() > 0) chk("rx_data", bus.rx_data_o, exp_rx.pop_front());
            else chk("rx_unexpected", bus.rx_data_o, 32'hFFFF_FFFF);
        end
    end

    // read-byte responder
    initial forever begin
        @(negedge clk);
        if (tx_force) begin
            tx_valid = 1; tx_data = 8'hFF;
        end else if (bus.tx_req_o && tx_q.size() > 0) begin
            tx_valid = 0;
            repeat (tx_delay) @(negedge clk);
            tx_data = tx_q.pop_front(); tx_valid = 1;
            @(negedge clk);
            tx_valid = 0;
        end else tx_valid = 0;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic scl_up();
        int t = 0;
        m_scl = 1;
        while (!bus.scl_i && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("scl_release", bus.scl_i, 1);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; wclk(T); scl_up(); wclk(T); m_scl = 0; wclk(2);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1; wclk(T); scl_up(); wclk(T / 2); b = bus.sda_i; wclk(T / 2); m_scl = 0; wclk(2);
    endtask

    task automatic bus_start();
        m_sda = 1; wclk(T); scl_up(); wclk(T); m_sda = 0; wclk(T); m_scl = 0; wclk(T);
    endtask

    task automatic bus_stop();
        m_sda = 0; wclk(T); scl_up(); wclk(T); m_sda = 1; wclk(4 * T);
    endtask

    task automatic put_byte(input logic [7:0] d, input string tag, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        chk(tag, a, exp_ack);
    endtask

    task automatic get_byte(input logic ack, input string tag);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
        if (exp_rd.size() > 0) chk(tag, d, exp_rd.pop_front());
        else chk({tag, "_unexpected"}, d, 32'hFFFF_FFFF);
    endtask

    initial begin
        int s_start, s_stop, s_nack, s_req, s_rx, s_str;
        wclk(3);
        @(negedge clk);
        chk("rst_sda", bus.sda_o, 1);
        chk("rst_scl", bus.scl_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rx_data", bus.rx_data_o, 0);
        chk("rst_tx_req", bus.tx_req_o, 0);
        chk("rst_rw", bus.rw_o, 0);
        rst_n = 1;
        wclk(5);

        // write 0x5A, 0xA5
        s_start = n_start; s_stop = n_stop; s_rx = n_rx;
        exp_rx.push_back(8'h5A); exp_rx.push_back(8'hA5);
        bus_start();
        put_byte(8'h44, "wr_addr_ack", 0);
        chk("wr_busy", bus.busy_o, 1);
        chk("wr_rw", bus.rw_o, 0);
        put_byte(8'h5A, "wr_d0_ack", 0);
        put_byte(8'hA5, "wr_d1_ack", 0);
        bus_stop();
        chk("wr_start_cnt", n_start - s_start, 1);
        chk("wr_stop_cnt", n_stop - s_stop, 1);
        chk("wr_rx_cnt", n_rx - s_rx, 2);
        chk("wr_busy_after", bus.busy_o, 0);

        // read 0xC3 with a 50-clock stretch, master NACK
        s_nack = n_nack; s_stop = n_stop;
        tx_delay = 50;
        tx_q.push_back(8'hC3); exp_rd.push_back(8'hC3);
        bus_start();
        put_byte(8'h45, "rd_addr_ack", 0);
        chk("rd_rw", bus.rw_o, 1);
        s_str = n_stretch;
        get_byte(1, "rd_byte");
        chk("rd_stretch_len", (n_stretch - s_str >= 49) && (n_stretch - s_str <= 53), 1);
        bus_stop();
        chk("rd_nack_cnt", n_nack - s_nack, 1);
        chk("rd_stop_cnt", n_stop - s_stop, 1);

        // wrong address
        s_start = n_start; s_stop = n_stop; s_rx = n_rx; s_req = n_req;
        bus_start();
        put_byte(8'h46, "bad_addr_nack", 1);
        bus_stop();
        chk("bad_start_cnt", n_start - s_start, 0);
        chk("bad_rx_cnt", n_rx - s_rx, 0);
        chk("bad_req_cnt", n_req - s_req, 0);
        chk("bad_stop_cnt", n_stop - s_stop, 0);
        chk("bad_scl_free", bus.scl_i, 1);
        chk("bad_sda_free", bus.sda_i, 1);

        // write then repeated START into a two-byte read
        s_start = n_start; s_nack = n_nack; s_stop = n_stop;
        tx_delay = 3;
        exp_rx.push_back(8'h10);
        tx_q.push_back(8'h77); tx_q.push_back(8'h78);
        exp_rd.push_back(8'h77); exp_rd.push_back(8'h78);
        bus_start();
        put_byte(8'h44, "rs_wr_addr_ack", 0);
        put_byte(8'h10, "rs_wr_d_ack", 0);
        bus_start();
        put_byte(8'h45, "rs_rd_addr_ack", 0);
        chk("rs_rw", bus.rw_o, 1);
        get_byte(0, "rs_rd_b0");
        get_byte(1, "rs_rd_b1");
        bus_stop();
        chk("rs_start_cnt", n_start - s_start, 2);
        chk("rs_nack_cnt", n_nack - s_nack, 1);
        chk("rs_stop_cnt", n_stop - s_stop, 1);

        // tx_valid held high during a write
        s_req = n_req;
        tx_force = 1;
        exp_rx.push_back(8'h99); exp_rx.push_back(8'h66);
        bus_start();
        put_byte(8'h44, "tv_addr_ack", 0);
        put_byte(8'h99, "tv_d0_ack", 0);
        put_byte(8'h66, "tv_d1_ack", 0);
        bus_stop();
        tx_force = 0;
        wclk(3);
        chk("tv_req_cnt", n_req - s_req, 0);
        chk("tv_rx_left", exp_rx.size(), 0);

        // reset during bit 4 of a written byte
        s_rx = n_rx; s_stop = n_stop;
        bus_start();
        put_byte(8'h44, "rr_addr_ack", 0);
        put_bit(1); put_bit(0); put_bit(1);
        m_sda = 0; wclk(T); scl_up(); wclk(2);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rr_sda_rel", bus.sda_o, 1);
        chk("rr_scl_rel", bus.scl_o, 1);
        chk("rr_busy", bus.busy_o, 0);
        m_sda = 1;
        wclk(5);
        rst_n = 1;
        wclk(10);
        chk("rr_rx_cnt", n_rx - s_rx, 0);
        chk("rr_stop_cnt", n_stop - s_stop, 0);
        s_start = n_start;
        exp_rx.push_back(8'h3C);
        bus_start();
        put_byte(8'h44, "rr2_addr_ack", 0);
        put_byte(8'h3C, "rr2_d_ack", 0);
        bus_stop();
        chk("rr2_start_cnt", n_start - s_start, 1);
        chk("rr2_rx_left", exp_rx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h22: 7-bit I2C address the block responds to.
REQ-002 SHALL have port clk_i, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port scl_i, input, 1: raw I2C clock from the bus; asynchronous.
REQ-005 SHALL have port sda_i, input, 1: raw I2C data from the bus; asynchronous.
REQ-006 SHALL have port scl_o, output, 1: open-drain clock; 0 pulls low, 1 releases the line.
REQ-007 SHALL have port sda_o, output, 1: open-drain data; 0 pulls low, 1 releases the line.
REQ-008 SHALL have port start_o, output, 1: one-cycle pulse when the address matches.
REQ-009 SHALL have port rw_o, output, 1: R/W bit of the last matched address; 1 = read.
REQ-010 SHALL have port stop_o, output, 1: one-cycle pulse on STOP that ends an addressed transfer.
REQ-011 SHALL have port rx_data_o, output, 8: last written byte, MSB first on the wire.
REQ-012 SHALL have port rx_valid_o, output, 1: one-cycle pulse when rx_data_o is updated.
REQ-013 SHALL have port tx_req_o, output, 1: level; the block needs a read byte.
REQ-014 SHALL have port tx_data_i, input, 8: read byte to send.
REQ-015 SHALL have port tx_valid_i, input, 1: accepted only in a cycle where tx_req_o=1.
REQ-016 SHALL have port tx_nack_o, output, 1: one-cycle pulse when the master NACKs a read byte.
REQ-017 SHALL have port busy_o, output, 1: high from the address match until STOP, repeated START or reset.

Function
REQ-018 SHALL pass scl_i and sda_i through 2-FF synchronizers; all detection uses the synchronized values.
REQ-019 SHALL detect START as sda falling while scl is high, and STOP as sda rising while scl is high.
REQ-020 SHALL detect START or STOP in every state, with priority over bit processing in the same cycle.
REQ-021 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK and SKIP.
REQ-022 SHALL go to ADDR on START, including a repeated START, from any state.
REQ-023 SHALL clear the bit counter and release sda_o and scl_o when it enters ADDR.
REQ-024 SHALL go to IDLE on STOP; stop_o pulses only if busy_o was 1.
REQ-025 SHALL sample bits on the synchronized scl rising edge and change sda_o only on the cycle after a synchronized scl falling edge.
REQ-026 ADDR: after 8 bits, SHALL go to ADDR_ACK if bits[7:1]==TARGET_ADDR, otherwise to SKIP with sda released (NACK); general call 7'h00 is not matched.
REQ-027 ADDR_ACK: on a match, SHALL pulse start_o, set rw_o and set busy_o.
REQ-028 ADDR_ACK: SHALL drive sda_o=0 from the 8th SCL falling edge to the 9th SCL falling edge.
REQ-029 ADDR_ACK: after the 9th SCL falling edge, SHALL go to WR_DATA if rw_o=0, otherwise to RD_WAIT.
REQ-030 WR_DATA: SHALL load rx_data_o and pulse rx_valid_o one cycle after the 8th SCL rising edge is detected.
REQ-031 WR_ACK: SHALL always ACK a written byte, using the same timing as ADDR_ACK, then return to WR_DATA.
REQ-032 RD_WAIT: SHALL set tx_req_o=1 and hold scl_o=0 (clock stretching) until tx_valid_i=1.
REQ-033 RD_WAIT: SHALL capture tx_data_i into a shift register in the tx_valid_i cycle and go to RD_DATA.
REQ-034 RD_WAIT: SHALL drop tx_req_o, drive the MSB on sda_o and release scl_o on the cycle after capture.
REQ-035 If tx_valid_i=1 in the same cycle tx_req_o rises, the byte SHALL be accepted with no stretch.
REQ-036 RD_DATA: SHALL shift out the next bit after each SCL falling edge; after 8 bits it SHALL release sda_o and go to RD_ACK.
REQ-037 RD_ACK: SHALL sample the master's ACK on the 9th SCL rising edge.
REQ-038 RD_ACK: if ACK (0), SHALL go to RD_WAIT on the next SCL falling edge; tx_req_o reasserts and SCL is stretched from that point.
REQ-039 RD_ACK: if NACK (1), SHALL pulse tx_nack_o and go to SKIP.
REQ-040 SKIP: SHALL keep sda_o=1 and scl_o=1, ignore tx_valid_i, and wait for START or STOP.
REQ-041 tx_valid_i while tx_req_o=0 SHALL have no effect.
REQ-042 scl_o SHALL be 0 only in RD_WAIT; sda_o SHALL be 0 only in ACK states or on a 0 read bit.

Reset
REQ-043 While rst_i=0, SHALL set the FSM to IDLE, synchronizers to 1, sda_o=1, scl_o=1, start_o=0, rw_o=0, stop_o=0, rx_data_o=8'h00, rx_valid_o=0, tx_req_o=0, tx_nack_o=0 and busy_o=0.
REQ-044 On reset mid-transfer, SHALL release both lines immediately, with no pulse outputs.
REQ-045 After release from a mid-transfer reset, SHALL respond only after a new START.

Structure
REQ-046 SHALL take state typedef i2c_target_state_t, I2C_ADDR_WIDTH=7 and I2C_DATA_WIDTH=8 from shared package i2c_pkg.
REQ-047 SHALL use one sub-module, i2c_line_sync (2-FF synchronizer plus rise/fall detect), instanced once for scl and once for sda.

Verification
REQ-048 Write to 0x22 with data 0x5A, 0xA5, then STOP -> address ACK; rx_valid_o pulses with 0x5A then 0xA5; both bytes ACKed; one stop_o pulse.
REQ-049 Read from 0x22, tx_valid_i with 0xC3 50 clocks after tx_req_o -> SCL held low about 50 clocks; bus shows 1,1,0,0,0,0,1,1; master NACK -> one tx_nack_o pulse.
REQ-050 Address 0x23 -> NACK; no start_o, rx_valid_o or tx_req_o pulses; bus free after STOP.
REQ-051 Write 0x22 data 0x10, repeated START, read 0x22 returning 0x77 and 0x78 (master ACK then NACK) -> rx 0x10, bytes 0x77 then 0x78, rw_o=1 after the second start_o.
REQ-052 rst_i low during bit 4 of a write byte -> sda_o=1 and scl_o=1 in the same cycle; a new transfer to 0x22 after reset completes correctly.
REQ-053 tx_valid_i held high through an entire write transfer -> ignored; received bytes are unaffected.
